seq_div_4by2: RTL and testbench
===============================

SEQ_DIV_4BY2 -- requirements
Module: seq_div_4by2

Interface
REQ-001 SHALL have parameter DW, default 4, dividend/quotient width.
REQ-002 SHALL have parameter VW, default 2, divisor/remainder width.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port dividend  input  DW  unsigned numerator, captured with start.
REQ-007 SHALL have port divisor  input  VW  unsigned denominator, captured with start.
REQ-008 SHALL have port busy  output  1  high in CALC and DONE.
REQ-009 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port quotient  output  DW  registered result.
REQ-011 SHALL have port remainder  output  VW  registered result.
REQ-012 SHALL have port div_by_zero  output  1  registered flag, valid with done.

Function
REQ-013 SHALL implement FSM IDLE, CALC, DONE.
- IDLE -> CALC: start=1, divisor!=0.
- IDLE -> DONE: start=1, divisor=0.
- CALC -> DONE: after exactly DW CALC cycles.
- DONE -> IDLE: unconditionally.
REQ-014 SHALL capture dividend and divisor on the edge that accepts start; input changes afterwards SHALL NOT affect the result.
REQ-015 SHALL perform one restoring step per CALC cycle, MSB first:
- pr = {pr[VW-1:0], next dividend bit}, pr width VW+1;
- if pr >= divisor: pr -= divisor and quotient bit = 1; otherwise quotient bit = 0.
REQ-016 SHALL hold partial remainder at VW+1 bits so that no step overflows.
REQ-017 SHALL assert done for exactly one cycle in DONE.
- Normal path: DW+1 edges after the accepting edge.
- Zero-divisor path: 1 edge after the accepting edge.
REQ-018 SHALL update quotient, remainder and div_by_zero on the edge entering DONE, and hold them until the next accepted start.
REQ-019 SHALL, on divisor=0, set div_by_zero=1, quotient=all ones and remainder=0.
REQ-020 SHALL clear div_by_zero when any subsequent start is accepted.
REQ-021 SHALL ignore start while busy=1; start held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-022 SHALL guarantee quotient*divisor+remainder == dividend and remainder < divisor for every nonzero divisor.

Reset
REQ-023 SHALL, on rst_n=0 at any time, including mid-CALC:
- go to IDLE immediately;
- drive busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0;
- discard any operation in progress.
REQ-024 SHALL leave reset synchronously with clk, and SHALL accept start no earlier than the first rising edge after rst_n rises.

Structure
REQ-025 SHALL place the state enum and the DW/VW default constants in shared package div_pkg.
REQ-026 SHALL factor the single restoring step, as a combinational circuit (pr_in, bit_in, divisor -> pr_out, q_bit), into sub-module div_step.
REQ-027 SHALL keep all outputs driven directly from registers.

Verification
REQ-028 SHALL cover: dividend=13, divisor=3, start 1 cycle -> done 5 edges later, quotient=4, remainder=1, div_by_zero=0.
REQ-029 SHALL cover: 15/1 then 0/2 back-to-back with start held high -> first result quotient=15, remainder=0; second quotient=0, remainder=0; done pulses 6 edges apart.
REQ-030 SHALL cover: dividend=9, divisor=0 -> done 1 edge later, div_by_zero=1, quotient=15, remainder=0; next 9/2 -> quotient=4, remainder=1, div_by_zero=0.
REQ-031 SHALL cover: start 7/2, then change inputs to 14/3 and pulse start during CALC -> quotient=3, remainder=1, single done pulse.
REQ-032 SHALL cover: rst_n low in the 2nd CALC cycle of 11/3 -> busy=0, done=0 and outputs 0 immediately; no done pulse; a fresh 11/3 gives quotient=3, remainder=2.
REQ-033 SHALL cover: exhaustive sweep of all 64 dividend/divisor pairs -> REQ-022 holds for each nonzero divisor, and REQ-019 holds for each zero divisor.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t : FSM encoding (IDLE, CALC, DONE)
//   DW_DEF  : default dividend/quotient width
//   VW_DEF  : default divisor/remainder width
package div_pkg;

  localparam int DW_DEF = 4;
  localparam int VW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   pr_in   [VW:0]   partial remainder from the previous step
//   bit_in           next dividend bit (MSB first)
//   divisor [VW-1:0] unsigned denominator
//   pr_out  [VW:0]   partial remainder after this step
//   q_bit            quotient bit produced by this step
module div_step #(
  parameter int VW = div_pkg::VW_DEF
) (
  input  logic [VW:0]   pr_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_out,
  output logic          q_bit
);

  // Shift is done at VW+2 bits so the compare and subtract see every
  // input bit; the result always fits back into VW+1 bits because the
  // incoming remainder is below the divisor.
  logic [VW+1:0] shifted;
  logic [VW+1:0] dvs_ext;

  always_comb begin
    shifted = {pr_in, bit_in};
    dvs_ext = {2'b00, divisor};
    q_bit   = (shifted >= dvs_ext);
    pr_out  = q_bit ? (VW+1)'(shifted - dvs_ext) : (VW+1)'(shifted);
  end

endmodule

// File: rtl/seq_div_4by2.sv
// Sequential unsigned divider, one restoring step per clock, MSB first.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (released synchronously)
//   start        request, sampled only in IDLE
//   dividend     [DW-1:0] numerator, captured with start
//   divisor      [VW-1:0] denominator, captured with start
//   busy         high in CALC and DONE
//   done         one-cycle result-valid pulse
//   quotient     [DW-1:0] registered result
//   remainder    [VW-1:0] registered result
//   div_by_zero  registered flag, valid with done
module seq_div_4by2
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  // Reset asserts asynchronously and releases on a clock edge.
  logic rst_meta;
  logic rst_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd_sh;   // remaining dividend bits shift out of the top, quotient bits enter at the bottom
  logic [VW-1:0] dvs;
  logic [VW:0]   pr;
  logic [VW:0]   pr_next;
  logic          q_bit;
  logic [DW-1:0] q_shift;
  logic          accept;
  logic          last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == CALC) && (cnt == CW'(DW - 1));
  assign q_shift   = (dvd_sh << 1) | DW'(q_bit);

  div_step #(.VW(VW)) u_step (
    .pr_in   (pr),
    .bit_in  (dvd_sh[DW-1]),
    .divisor (dvs),
    .pr_out  (pr_next),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands and working registers: no reset needed, they are always
  // loaded on accept before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_sh <= dividend;
      dvs    <= divisor;
      pr     <= '0;
    end else if (state == CALC) begin
      dvd_sh <= q_shift;
      pr     <= pr_next;
    end
  end

  // Control and registered outputs.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);

      if (accept) cnt <= '0;
      else if (state == CALC) cnt <= cnt + CW'(1);

      if (accept) begin
        div_by_zero <= (divisor == '0);
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= '0;
        end
      end

      if (last_step) begin
        quotient  <= q_shift;
        remainder <= pr_next[VW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_div_4by2.sv
module tb_seq_div_4by2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [1:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  int         lat;
  logic [3:0] q_seen;
  logic [1:0] r_seen;
  logic       z_seen;

  always #5 clk = ~clk;

  seq_div_4by2 #(.DW(4), .VW(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE, counts edges (accepting edge = 1) until
  // done, records the results, checks done falls, and returns to IDLE.
  task automatic run_op(input logic [3:0] a, input logic [1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    q_seen = quotient;
    r_seen = remainder;
    z_seen = div_by_zero;
    tick();
    check("done_fall", int'(done), 0);
  endtask

  initial begin
    int n;
    int pulses;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dz", int'(div_by_zero), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 13 / 3
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 2'd3;
    tick();
    start = 1'b0;
    check("13_3_busy", int'(busy), 1);
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("13_3_lat", lat, 5);
    check("13_3_q", int'(quotient), 4);
    check("13_3_r", int'(remainder), 1);
    check("13_3_dz", int'(div_by_zero), 0);
    tick();
    check("13_3_done_fall", int'(done), 0);
    check("13_3_idle", int'(busy), 0);

    // 15/1 then 0/2 back to back, start held high
    start    = 1'b1;
    dividend = 4'd15;
    divisor  = 2'd1;
    tick();
    dividend = 4'd0;
    divisor  = 2'd2;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_lat1", lat, 5);
    check("b2b_q1", int'(quotient), 15);
    check("b2b_r1", int'(remainder), 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 20);
    start = 1'b0;
    check("b2b_gap", n, 6);
    check("b2b_q2", int'(quotient), 0);
    check("b2b_r2", int'(remainder), 0);
    tick();

    // 9 / 0, then 9 / 2
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 2'd0;
    tick();
    start = 1'b0;
    check("dz_done", int'(done), 1);
    check("dz_busy", int'(busy), 1);
    check("dz_flag", int'(div_by_zero), 1);
    check("dz_q", int'(quotient), 15);
    check("dz_r", int'(remainder), 0);
    tick();
    check("dz_done_fall", int'(done), 0);
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 2'd2;
    tick();
    start = 1'b0;
    check("dz_clear_on_start", int'(div_by_zero), 0);
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("9_2_lat", lat, 5);
    check("9_2_q", int'(quotient), 4);
    check("9_2_r", int'(remainder), 1);
    check("9_2_dz", int'(div_by_zero), 0);
    tick();

    // 7 / 2 with inputs changed and start pulsed during CALC
    start    = 1'b1;
    dividend = 4'd7;
    divisor  = 2'd2;
    tick();
    start    = 1'b0;
    dividend = 4'd14;
    divisor  = 2'd3;
    tick();
    start = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        pulses++;
        q_seen = quotient;
        r_seen = remainder;
      end
      tick();
    end
    check("ign_pulses", pulses, 1);
    check("ign_q", int'(q_seen), 3);
    check("ign_r", int'(r_seen), 1);

    // Reset in the second CALC cycle of 11 / 3
    start    = 1'b1;
    dividend = 4'd11;
    divisor  = 2'd3;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_q", int'(quotient), 0);
    check("mid_rst_r", int'(remainder), 0);
    check("mid_rst_dz", int'(div_by_zero), 0);
    tick();
    tick();
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    run_op(4'd11, 2'd3);
    check("fresh_11_3_lat", lat, 5);
    check("fresh_11_3_q", int'(q_seen), 3);
    check("fresh_11_3_r", int'(r_seen), 2);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        run_op(4'(a), 2'(b));
        if (b == 0) begin
          check("sweep_lat_z", lat, 1);
          check("sweep_dz_z", int'(z_seen), 1);
          check("sweep_q_z", int'(q_seen), 15);
          check("sweep_r_z", int'(r_seen), 0);
        end else begin
          check("sweep_lat", lat, 5);
          check("sweep_dz", int'(z_seen), 0);
          check("sweep_identity", int'(q_seen) * b + int'(r_seen), a);
          check("sweep_r_lt", int'(int'(r_seen) < b), 1);
          check("sweep_q", int'(q_seen), a / b);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
